// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_EARLY_EN to let zero multiplies and mandated divide cases finish in one cycle.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] b_q;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic        spec_q;
    logic [31:0] spec_val_q;

    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic        spec_c;
    logic [31:0] spec_val_c;
    logic        early_go;

    // Accept-time decode: operand signs, magnitudes and the RISC-V mandated corner cases.
    always_comb begin
        a_signed   = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
        b_signed   = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
        a_neg      = a_signed & rs1_i[31];
        b_neg      = b_signed & rs2_i[31];
        a_mag      = a_neg ? (32'd0 - rs1_i) : rs1_i;
        b_mag      = b_neg ? (32'd0 - rs2_i) : rs2_i;
        div_zero   = op_i[2] && (rs2_i == 32'd0);
        div_ovf    = op_i[2] && !op_i[0] && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
        spec_c     = div_zero || div_ovf;
        spec_val_c = 32'd0;
        if (div_zero)
            spec_val_c = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
        else if (div_ovf)
            spec_val_c = op_i[1] ? 32'd0 : 32'h8000_0000;
`ifdef MULDIV_EARLY_EN
        early_go = spec_c || (!op_i[2] && ((rs1_i == 32'd0) || (rs2_i == 32'd0)));
`else
        early_go = 1'b0;
`endif
    end

    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] div_sub;

    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'd0);
        rem_sh  = acc[63:31];
        div_ge  = (rem_sh >= {1'b0, b_q});
        // When rem_sh >= divisor the true difference is below 2^32, so 32 bits suffice.
        div_sub = rem_sh[31:0] - b_q;
    end

    logic        sign_diff;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] adj_res;

    always_comb begin
        sign_diff = neg_a ^ neg_b;
        prod      = sign_diff ? (64'd0 - acc) : acc;
        quot      = sign_diff ? (32'd0 - acc[31:0]) : acc[31:0];
        rem       = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];
        case (op_q)
            3'b000:                 adj_res = prod[31:0];
            3'b001, 3'b010, 3'b011: adj_res = prod[63:32];
            3'b100, 3'b101:         adj_res = quot;
            default:                adj_res = rem;
        endcase
        if (spec_q)
            adj_res = spec_val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= 32'd0;
            op_q       <= 3'd0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            b_q        <= 32'd0;
            acc        <= 64'd0;
            cnt        <= 5'd0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
        end else if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        op_q       <= op_i;
                        neg_a      <= a_neg;
                        neg_b      <= b_neg;
                        b_q        <= b_mag;
                        acc        <= {32'd0, a_mag};
                        cnt        <= 5'd0;
                        spec_q     <= spec_c;
                        spec_val_q <= spec_val_c;
                        busy_o     <= 1'b1;
                        if (early_go) begin
                            result_o <= spec_val_c;
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2])
                        acc <= div_ge ? {div_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
                    else
                        acc <= {mul_sum, acc[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= ADJ;
                end
                ADJ: begin
                    result_o <= adj_res;
                    done_o   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: arithmetic, mandated cases, timing, flush, reset.
module tb_muldiv_seq;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

`ifdef MULDIV_EARLY_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 34;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total;
    int bad;

    muldiv_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .op_i     (op),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .flush_i  (flush),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and report the cycle (after accept) in which done_o is seen.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        res = 32'd0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h expected 00000000", result); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int l;
        do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, r, l);
        total++; if (r !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_7_m3: got %h expected ffffffeb", r); end
        total++; if (l !== 34) begin bad++; $display("FAIL mul_latency: got %0d expected 34", l); end
        do_op(OP_MULH, 32'd7, 32'hFFFF_FFFD, r, l);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulh_7_m3: got %h expected ffffffff", r); end
        do_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, r, l);
        total++; if (r !== 32'h4000_0000) begin bad++; $display("FAIL mulh_min: got %h expected 40000000", r); end
        do_op(OP_MULHU, 32'h8000_0000, 32'h8000_0000, r, l);
        total++; if (r !== 32'h4000_0000) begin bad++; $display("FAIL mulhu_min: got %h expected 40000000", r); end
        do_op(OP_MULHSU, 32'h8000_0000, 32'h8000_0000, r, l);
        total++; if (r !== 32'hC000_0000) begin bad++; $display("FAIL mulhsu_min: got %h expected c0000000", r); end
        do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu_max: got %h expected fffffffe", r); end
    endtask

    task automatic test_div();
        logic [31:0] r;
        int l;
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, l);
        total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_m7_2: got %h expected fffffffd", r); end
        total++; if (l !== 34) begin bad++; $display("FAIL div_latency: got %0d expected 34", l); end
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, l);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_m7_2: got %h expected ffffffff", r); end
        do_op(OP_DIVU, 32'd100, 32'd7, r, l);
        total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_100_7: got %h expected 0000000e", r); end
        do_op(OP_REMU, 32'd100, 32'd7, r, l);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_100_7: got %h expected 00000002", r); end
        do_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, r, l);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL divu_large: got %h expected 00000001", r); end
        do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, r, l);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL rem_7_m2: got %h expected 00000001", r); end
    endtask

    task automatic test_special();
        logic [31:0] r;
        int l;
        do_op(OP_DIVU, 32'd100, 32'd0, r, l);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_by_zero: got %h expected ffffffff", r); end
        total++; if (l !== SPEC_LAT) begin bad++; $display("FAIL divz_latency: got %0d expected %0d", l, SPEC_LAT); end
        do_op(OP_REM, 32'd100, 32'd0, r, l);
        total++; if (r !== 32'd100) begin bad++; $display("FAIL rem_by_zero: got %h expected 00000064", r); end
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, r, l);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_by_zero: got %h expected ffffffff", r); end
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, l);
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL div_overflow: got %h expected 80000000", r); end
        total++; if (l !== SPEC_LAT) begin bad++; $display("FAIL ovf_latency: got %0d expected %0d", l, SPEC_LAT); end
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, l);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL rem_overflow: got %h expected 00000000", r); end
        do_op(OP_MUL, 32'd0, 32'd12345, r, l);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL mul_zero: got %h expected 00000000", r); end
        total++; if (l !== SPEC_LAT) begin bad++; $display("FAIL mul_zero_latency: got %0d expected %0d", l, SPEC_LAT); end
    endtask

    task automatic test_timing();
        logic exp_busy;
        logic exp_done;
        @(negedge clk);
        op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            exp_busy = (k <= 34);
            exp_done = (k == 34);
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL timing_busy c%0d: got %b expected %b", k, busy, exp_busy); end
            total++; if (done !== exp_done) begin bad++; $display("FAIL timing_done c%0d: got %b expected %b", k, done, exp_done); end
        end
        total++; if (result !== 32'd15) begin bad++; $display("FAIL timing_result: got %h expected 0000000f", result); end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        int done_cyc;
        prev = result;
        @(negedge clk);
        op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) flush = 1'b1;
        end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done: got %b expected 0", done); end
        total++; if (result !== prev) begin bad++; $display("FAIL flush_result: got %h expected %h", result, prev); end
        op = OP_MUL; rs1 = 32'd6; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = -1;
        for (int k = 12; k <= 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin done_cyc = k; break; end
        end
        total++; if (done_cyc !== 45) begin bad++; $display("FAIL flush_next_cycle: got %0d expected 45", done_cyc); end
        total++; if (result !== 32'd42) begin bad++; $display("FAIL flush_next_result: got %h expected 0000002a", result); end
        @(negedge clk);
        op = OP_DIV; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op = OP_MUL; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_mid_result: got %h expected 00000000", result); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_after: got busy %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        logic exp_done;
        @(negedge clk);
        op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 106; k++) begin
            @(negedge clk);
            exp_busy = ((k % 35) != 0);
            exp_done = (k == 34) || (k == 69) || (k == 104);
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL b2b_busy c%0d: got %b expected %b", k, busy, exp_busy); end
            total++; if (done !== exp_done) begin bad++; $display("FAIL b2b_done c%0d: got %b expected %b", k, done, exp_done); end
            if (exp_done) begin
                total++; if (result !== 32'd15) begin bad++; $display("FAIL b2b_result c%0d: got %h expected 0000000f", k, result); end
            end
        end
        start = 1'b0;
        for (int k = 0; k < 60 && busy === 1'b1; k++) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain: got busy %b expected 0", busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        rs1   = 32'd0;
        rs2   = 32'd0;
        flush = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_timing();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
